// File: rtl/hcsr04_pkg.sv
// +--------------------------------------------------------------------+
// | hcsr04_pkg                                                         |
// | Shared FSM encoding, output widths and default timing constants    |
// | for the HC-SR04 ultrasonic ranger.                                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package hcsr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int c_echo_w = 22;
  localparam int c_dist_w = 10;

  // Defaults assume a 100 MHz clock.
  localparam int c_clk_hz      = 100_000_000;
  localparam int c_trig_cyc    = 1_000;
  localparam int c_timeout_cyc = 3_800_000;
  localparam int c_holdoff_cyc = 6_000_000;
  localparam int c_cm_div      = 5_800;

endpackage

`default_nettype wire

// File: rtl/hcsr04_echo_sync.sv
// +--------------------------------------------------------------------+
// | hcsr04_echo_sync                                                   |
// | Two-flop synchronizer for the echo pin with rise/fall detection.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hcsr04_echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_echo,
  output logic o_echo,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_echo;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_echo = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/hcsr04_ranger.sv
// +--------------------------------------------------------------------+
// | hcsr04_ranger                                                      |
// | HC-SR04 trigger/echo sequencer; echo width in cycles and, when     |
// | HCSR04_CM_CONV_EN is defined, distance in centimetres.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int CLK_HZ      = c_clk_hz,
  parameter int TRIG_CYC    = c_trig_cyc,
  parameter int TIMEOUT_CYC = c_timeout_cyc,
  parameter int HOLDOFF_CYC = c_holdoff_cyc,
  parameter int CM_DIV      = c_cm_div
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start_i,
  input  logic                echo_i,
  output logic                trig_o,
  output logic                busy_o,
  output logic                valid_o,
  output logic                timeout_o,
  output logic [c_echo_w-1:0] echo_cycles_o,
  output logic [c_dist_w-1:0] dist_cm_o
);

  localparam int c_trig_w = $clog2(TRIG_CYC + 1);
  localparam int c_to_w   = $clog2(TIMEOUT_CYC + 1);
  localparam int c_hold_w = $clog2(HOLDOFF_CYC + 1);

  localparam logic [c_trig_w-1:0] c_trig_last = c_trig_w'(TRIG_CYC - 1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYC - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLDOFF_CYC - 1);

  if (CLK_HZ < 1 || TRIG_CYC < 1 || TIMEOUT_CYC < 2 || HOLDOFF_CYC < 1 || CM_DIV < 1)
  begin : g_param_check
    $error("hcsr04_ranger: invalid timing parameters");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic w_echo;
  logic w_rise;
  logic w_fall;
  logic w_done_ok;
  logic w_done_to;
  logic w_done_sat;

  logic [c_trig_w-1:0] r_trig_cnt;
  logic [c_to_w-1:0]   r_wait_cnt;
  logic [c_to_w-1:0]   r_echo_cnt;
  logic [c_to_w-1:0]   w_echo_inc;
  logic [c_hold_w-1:0] r_hold_cnt;

  logic                r_trig;
  logic                r_valid;
  logic                r_timeout;
  logic [c_echo_w-1:0] r_echo_cycles;

  hcsr04_echo_sync u_echo_sync (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .i_echo (echo_i),
    .o_echo (w_echo),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_echo_inc = r_echo_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    w_done_sat  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_TRIG;
      end
      ST_TRIG: begin
        if (r_trig_cnt == c_trig_last) w_state_nxt = ST_WAIT_ECHO;
      end
      ST_WAIT_ECHO: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
        end else if (r_wait_cnt == c_to_last) begin
          w_done_to   = 1'b1;
          w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_MEASURE: begin
        if (w_fall) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_HOLDOFF;
        end else if (w_echo && r_echo_cnt >= c_to_last) begin
          w_done_sat  = 1'b1;
          w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == c_hold_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The rise cycle is already one high cycle, so the echo count enters MEASURE at 1.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_trig_cnt    <= '0;
      r_wait_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_echo_cnt    <= '0;
      r_trig        <= 1'b0;
      r_valid       <= 1'b0;
      r_timeout     <= 1'b0;
      r_echo_cycles <= '0;
    end else begin
      r_trig     <= (w_state_nxt == ST_TRIG);
      r_trig_cnt <= (r_state == ST_TRIG && w_state_nxt == ST_TRIG) ? r_trig_cnt + 1'b1 : '0;
      r_wait_cnt <= (r_state == ST_WAIT_ECHO && w_state_nxt == ST_WAIT_ECHO) ?
                    r_wait_cnt + 1'b1 : '0;
      r_hold_cnt <= (r_state == ST_HOLDOFF && w_state_nxt == ST_HOLDOFF) ?
                    r_hold_cnt + 1'b1 : '0;

      if (r_state == ST_WAIT_ECHO)            r_echo_cnt <= c_to_w'(1);
      else if (r_state == ST_MEASURE && w_echo) r_echo_cnt <= w_echo_inc;

      r_valid <= w_done_ok | w_done_to | w_done_sat;
      if (w_done_to) begin
        r_timeout     <= 1'b1;
        r_echo_cycles <= '0;
      end else if (w_done_sat) begin
        r_timeout     <= 1'b1;
        r_echo_cycles <= c_echo_w'(w_echo_inc);
      end else if (w_done_ok) begin
        r_timeout     <= 1'b0;
        r_echo_cycles <= c_echo_w'(r_echo_cnt);
      end
    end
  end

`ifdef HCSR04_CM_CONV_EN
  localparam int c_div_w = $clog2(CM_DIV + 1);
  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CM_DIV - 1);
  localparam logic [c_div_w-1:0]  c_presc_ini = c_div_w'(1 % CM_DIV);
  localparam logic [c_dist_w-1:0] c_dist_ini  = c_dist_w'((CM_DIV == 1) ? 1 : 0);
  localparam logic [c_dist_w-1:0] c_dist_max  = '1;

  logic [c_div_w-1:0]  r_presc;
  logic [c_dist_w-1:0] r_dist;
  logic [c_dist_w-1:0] w_dist_inc;
  logic [c_dist_w-1:0] r_dist_cm;
  logic                w_wrap;

  assign w_wrap     = (r_presc == c_div_last);
  assign w_dist_inc = (r_dist == c_dist_max) ? r_dist : r_dist + 1'b1;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_presc   <= '0;
      r_dist    <= '0;
      r_dist_cm <= '0;
    end else begin
      if (r_state == ST_WAIT_ECHO) begin
        r_presc <= c_presc_ini;
        r_dist  <= c_dist_ini;
      end else if (r_state == ST_MEASURE && w_echo) begin
        r_presc <= w_wrap ? '0 : r_presc + 1'b1;
        if (w_wrap) r_dist <= w_dist_inc;
      end

      if (w_done_to)       r_dist_cm <= '0;
      else if (w_done_sat) r_dist_cm <= w_wrap ? w_dist_inc : r_dist;
      else if (w_done_ok)  r_dist_cm <= r_dist;
    end
  end

  assign dist_cm_o = r_dist_cm;
`else
  assign dist_cm_o = '0;
`endif

  assign trig_o        = r_trig;
  assign busy_o        = (r_state != ST_IDLE);
  assign valid_o       = r_valid;
  assign timeout_o     = r_timeout;
  assign echo_cycles_o = r_echo_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hcsr04_ranger.sv
// +--------------------------------------------------------------------+
// | tb_hcsr04_ranger                                                   |
// | Directed self-checking bench for hcsr04_ranger (short timings).    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hcsr04_ranger;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        start_i;
  logic        echo_i;
  logic        trig_o;
  logic        busy_o;
  logic        valid_o;
  logic        timeout_o;
  logic [21:0] echo_cycles_o;
  logic [9:0]  dist_cm_o;

`ifdef HCSR04_CM_CONV_EN
  localparam int c_dist_nom = 10;
  localparam int c_dist_sat = 17;
  localparam int c_dist_106 = 1;
`else
  localparam int c_dist_nom = 0;
  localparam int c_dist_sat = 0;
  localparam int c_dist_106 = 0;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_valid = 0;

  always #5 ACLK = ~ACLK;

  hcsr04_ranger #(
    .CLK_HZ      (100_000_000),
    .TRIG_CYC    (10),
    .TIMEOUT_CYC (1000),
    .HOLDOFF_CYC (50),
    .CM_DIV      (58)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start_i       (start_i),
    .echo_i        (echo_i),
    .trig_o        (trig_o),
    .busy_o        (busy_o),
    .valid_o       (valid_o),
    .timeout_o     (timeout_o),
    .echo_cycles_o (echo_cycles_o),
    .dist_cm_o     (dist_cm_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive and sample 1 time unit after each rising edge.
  task automatic step();
    @(posedge ACLK);
    #1;
    if (valid_o === 1'b1) n_valid++;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic trig_width(input int extra_at, output int n);
    n = 0;
    while (trig_o === 1'b1 && n < 100) begin
      start_i = (n == extra_at);
      n++;
      step();
    end
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound, output int c);
    c = 0;
    while (valid_o !== 1'b1 && c < bound) begin
      step();
      c++;
    end
    check(tag, valid_o, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound, output int c);
    c = 0;
    while (busy_o !== 1'b0 && c < bound) begin
      step();
      c++;
    end
    check(tag, busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"},    trig_o, 0);
    check({tag, "_busy"},    busy_o, 0);
    check({tag, "_valid"},   valid_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_echo"},    echo_cycles_o, 0);
    check({tag, "_dist"},    dist_cm_o, 0);
  endtask

  task automatic run_nominal(input string tag);
    int n;
    int c;
    n_valid = 0;
    pulse_start();
    check({tag, "_trig_on"}, trig_o, 1);
    check({tag, "_busy_on"}, busy_o, 1);
    trig_width(-1, n);
    check({tag, "_trig_width"}, n, 10);
    repeat (20) step();
    echo_i = 1'b1;
    repeat (580) step();
    echo_i = 1'b0;
    wait_valid({tag, "_valid"}, 20, c);
    check({tag, "_echo"},    echo_cycles_o, 580);
    check({tag, "_dist"},    dist_cm_o, c_dist_nom);
    check({tag, "_timeout"}, timeout_o, 0);
    wait_idle({tag, "_idle"}, 100, c);
    check({tag, "_echo_hold"}, echo_cycles_o, 580);
    check({tag, "_nvalid"},    n_valid, 1);
  endtask

  initial begin
    int n;
    int c;
    ARESETN = 1'b0;
    start_i = 1'b0;
    echo_i  = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    ARESETN = 1'b1;

    // First edge after release accepts start.
    run_nominal("nom1");

    // Echo never rises.
    n_valid = 0;
    pulse_start();
    trig_width(-1, n);
    check("to_trig_width", n, 10);
    wait_valid("to_valid", 2000, c);
    check("to_latency", c, 1000);
    check("to_timeout", timeout_o, 1);
    check("to_echo",    echo_cycles_o, 0);
    check("to_dist",    dist_cm_o, 0);
    wait_idle("to_idle", 100, c);
    check("to_nvalid", n_valid, 1);

    // Echo rises and stays high past the limit.
    n_valid = 0;
    pulse_start();
    trig_width(-1, n);
    repeat (5) step();
    echo_i = 1'b1;
    wait_valid("sat_valid", 1200, c);
    check("sat_echo",    echo_cycles_o, 1000);
    check("sat_timeout", timeout_o, 1);
    check("sat_dist",    dist_cm_o, c_dist_sat);
    echo_i = 1'b0;
    wait_idle("sat_idle", 100, c);
    check("sat_nvalid", n_valid, 1);

    // Extra starts in TRIG, MEASURE and HOLDOFF are ignored.
    n_valid = 0;
    pulse_start();
    trig_width(3, n);
    check("ext_trig_width", n, 10);
    repeat (10) step();
    echo_i = 1'b1;
    repeat (5) step();
    pulse_start();
    repeat (100) step();
    echo_i = 1'b0;
    wait_valid("ext_valid", 20, c);
    check("ext_echo",    echo_cycles_o, 106);
    check("ext_dist",    dist_cm_o, c_dist_106);
    check("ext_timeout", timeout_o, 0);
    c = 0;
    while (busy_o !== 1'b0 && c < 200) begin
      start_i = (c == 10);
      step();
      c++;
    end
    start_i = 1'b0;
    check("ext_holdoff_len", c, 50);
    check("ext_nvalid", n_valid, 1);
    pulse_start();
    check("ext_next_accepted", trig_o, 1);

    // Reset during TRIG drops the pin without a clock edge.
    repeat (3) step();
    ARESETN = 1'b0;
    #1;
    check("rst_trig_async", trig_o, 0);
    check("rst_trig_busy",  busy_o, 0);
    step();
    ARESETN = 1'b1;

    // Reset mid-MEASURE.
    pulse_start();
    trig_width(-1, n);
    check("rstm_trig_width", n, 10);
    repeat (5) step();
    echo_i = 1'b1;
    repeat (30) step();
    ARESETN = 1'b0;
    #1;
    check_all_zero("rstm");
    echo_i = 1'b0;
    step();
    step();
    ARESETN = 1'b1;
    run_nominal("nom2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hcsr04_ranger.md
HCSR04_RANGER -- requirements
Module: hcsr04_ranger

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: ACLK frequency, informative only.
REQ-002 SHALL have parameter TRIG_CYC, default 1000: trigger pulse width in cycles (10 us).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 3800000: maximum wait and maximum echo width in cycles (38 ms).
REQ-004 SHALL have parameter HOLDOFF_CYC, default 6000000: quiet time after each measurement (60 ms).
REQ-005 SHALL have parameter CM_DIV, default 5800: cycles per centimetre (58 us).
REQ-006 SHALL have port ACLK, input, 1 bit: the single clock.
REQ-007 SHALL have port ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start_i, input, 1 bit: measurement request pulse from the AXI register slave.
REQ-009 SHALL have port echo_i, input, 1 bit: asynchronous sensor echo pin.
REQ-010 SHALL have port trig_o, output, 1 bit: sensor trigger pin.
REQ-011 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port valid_o, output, 1 bit: one-cycle completion strobe to the register slave.
REQ-013 SHALL have port timeout_o, output, 1 bit: last result timed out.
REQ-014 SHALL have port echo_cycles_o, output, 22 bits: last echo width in cycles.
REQ-015 SHALL have port dist_cm_o, output, 10 bits: last distance in cm.

Function
REQ-016 SHALL pass echo_i through a 2-flop synchronizer with rise/fall detect before any use.
REQ-017 SHALL implement the FSM states IDLE, TRIG, WAIT_ECHO, MEASURE and HOLDOFF.
REQ-018 SHALL move IDLE->TRIG when start_i=1 in IDLE; start_i in any other state SHALL be ignored and SHALL NOT be queued.
REQ-019 SHALL drive trig_o high from the cycle after start_i is sampled for exactly TRIG_CYC cycles, then enter WAIT_ECHO.
REQ-020 SHALL move WAIT_ECHO->MEASURE on a synchronized rising edge only; a level already high SHALL NOT count.
REQ-021 SHALL, after TIMEOUT_CYC cycles in WAIT_ECHO, set timeout, set echo_cycles=0 and dist_cm=0, pulse valid_o, and enter HOLDOFF.
REQ-022 SHALL, in MEASURE, increment echo_cycles once per cycle while synchronized echo is high; the result SHALL equal the high width in cycles.
REQ-023 SHALL, in MEASURE, increment dist_cm each time a CM_DIV prescaler wraps; the prescaler SHALL reset on MEASURE entry, and dist_cm SHALL saturate at 1023.
REQ-024 SHALL, on a synchronized falling edge in MEASURE, pulse valid_o the next cycle with timeout=0, then enter HOLDOFF.
REQ-025 SHALL, when echo_cycles reaches TIMEOUT_CYC in MEASURE, saturate echo_cycles at TIMEOUT_CYC, set timeout=1, pulse valid_o, and enter HOLDOFF.
REQ-026 SHALL stay in HOLDOFF for HOLDOFF_CYC cycles, then return to IDLE.
REQ-027 SHALL hold echo_cycles_o, dist_cm_o and timeout_o stable between valid_o pulses and update them only in the valid_o cycle.
REQ-028 SHALL keep valid_o high for exactly one cycle per accepted start_i.

Reset
REQ-029 SHALL, while ARESETN=0, force FSM=IDLE, trig_o=0, busy_o=0, valid_o=0, timeout_o=0, echo_cycles_o=0, dist_cm_o=0, all counters=0, and synchronizer flops=0.
REQ-030 SHALL, when reset is asserted mid-operation, drop trig_o asynchronously without waiting for ACLK.
REQ-031 SHALL accept start_i on the first edge after reset release.

Configuration
REQ-032 SHALL compile the CM_DIV prescaler and dist_cm logic only when macro HCSR04_CM_CONV_EN is defined.
REQ-033 SHALL, without HCSR04_CM_CONV_EN, tie dist_cm_o to 0 and leave all other behaviour unchanged.

Structure
REQ-034 SHALL take the FSM state enum, output widths (22, 10) and default timing constants from package hcsr04_pkg.
REQ-035 SHALL place the synchronizer and edge detect in sub-module hcsr04_echo_sync.
REQ-036 SHALL size each counter by clog2 of its parameter.

Verification (TRIG_CYC=10, TIMEOUT_CYC=1000, HOLDOFF_CYC=50, CM_DIV=58)
REQ-037 SHALL cover: start_i pulse, echo high for 580 cycles starting 20 cycles after trig falls -> trig_o high exactly 10 cycles, one valid_o, echo_cycles_o=580, dist_cm_o=10, timeout_o=0.
REQ-038 SHALL cover: start_i with echo held low -> valid_o 1000 cycles after WAIT_ECHO entry, timeout_o=1, echo_cycles_o=0, dist_cm_o=0.
REQ-039 SHALL cover: echo rises and stays high -> valid_o with echo_cycles_o=1000, timeout_o=1, dist_cm_o=17.
REQ-040 SHALL cover: extra start_i pulses during TRIG, MEASURE and HOLDOFF -> exactly one valid_o, busy_o low only after 50 HOLDOFF cycles; a following start_i is accepted.
REQ-041 SHALL cover: ARESETN=0 mid-MEASURE -> trig_o=0, busy_o=0, all outputs 0 immediately; after release, scenario REQ-037 passes again.
REQ-042 SHALL cover: build without HCSR04_CM_CONV_EN, scenario REQ-037 -> dist_cm_o=0 and all other values unchanged.
